// File: rtl/csla_pkg.sv
// Shared constants and state encoding for the carry select adder and its accumulator.
package csla_pkg;
  localparam int CSLA_WIDTH   = 32;
  localparam int CSLA_CNT_W   = 8;
  localparam int CSLA_CARRY_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } acc_state_t;
endpackage

// File: rtl/csla.sv
// 32-bit carry select adder: each block precomputes both carry-in cases, and the
// ripple of block carries only drives the select muxes.
module csla
  import csla_pkg::*;
#(
  parameter int WIDTH = CSLA_WIDTH,
  parameter int BLK   = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic             cout
);
  localparam int NB = WIDTH / BLK;

  logic [NB:0] c;
  assign c[0] = 1'b0;

  for (genvar b = 0; b < NB; b++) begin : g_blk
    logic [BLK:0] r0, r1;
    assign r0 = {1'b0, x[b*BLK +: BLK]} + {1'b0, y[b*BLK +: BLK]};
    assign r1 = {1'b0, x[b*BLK +: BLK]} + {1'b0, y[b*BLK +: BLK]} + (BLK+1)'(1);
    assign s[b*BLK +: BLK] = c[b] ? r1[BLK-1:0] : r0[BLK-1:0];
    assign c[b+1]          = c[b] ? r1[BLK]     : r0[BLK];
  end

  assign cout = c[NB];
endmodule

// File: rtl/csla_accumulator.sv
// Burst accumulator around one csla; carry-outs are counted in an extension counter.
// Define CSLA_ACCUMULATOR_OVF_EN to add the sticky ovf flag for extension-counter wrap.
module csla_accumulator
  import csla_pkg::*;
#(
  parameter int WIDTH   = CSLA_WIDTH,
  parameter int CNT_W   = CSLA_CNT_W,
  parameter int CARRY_W = CSLA_CARRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_sum,
  output logic [CARRY_W-1:0] out_carry,
  output logic               busy
`ifdef CSLA_ACCUMULATOR_OVF_EN
  ,
  output logic               ovf
`endif
);
  acc_state_t         state, state_n;
  logic [WIDTH-1:0]   acc;
  logic [CARRY_W-1:0] carry;
  logic [CNT_W-1:0]   remaining;
  logic [WIDTH-1:0]   s;
  logic               cout;
  logic               hs;

  csla #(.WIDTH(WIDTH)) u_csla (
    .x    (acc),
    .y    (in_data),
    .s    (s),
    .cout (cout)
  );

  assign hs = (state == ACC) && in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = (len != '0) ? ACC : DONE;
      ACC:  if (hs && remaining == CNT_W'(1)) state_n = DONE;
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      carry     <= '0;
      remaining <= '0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      carry     <= '0;
      remaining <= len;
    end else if (hs) begin
      acc       <= s;
      carry     <= carry + CARRY_W'(cout);
      remaining <= remaining - CNT_W'(1);
    end
  end

`ifdef CSLA_ACCUMULATOR_OVF_EN
  // Wrap happens exactly when a carry arrives while the counter is all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf <= 1'b0;
    else if (state == IDLE && start) ovf <= 1'b0;
    else if (hs && cout && &carry)   ovf <= 1'b1;
  end
`endif

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = acc;
  assign out_carry = carry;
endmodule
